// File: rtl/ters_bit_degistirme.sv
// Iterative AES InvSubBytes: inverse S-box over a 128-bit state, BYTES_PER_CYCLE bytes per cycle.
// Latency: cikan_gecerli rises 16/BYTES_PER_CYCLE edges after the accept edge; one job in flight.
// Backpressure: result held in HAZIR until cikan_hazir; giren_hazir low from accept until BOSTA.
// Option INV_SBOX_SELFCHECK_EN: forward S-box recheck of every byte, sticky ters_hata output.
module ters_bit_degistirme #(
   parameter int BYTES_PER_CYCLE = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         giren_gecerli,
   output logic         giren_hazir,
   input  logic [127:0] giren_kod,
   output logic         cikan_gecerli,
   input  logic         cikan_hazir,
   output logic [127:0] cikan_kod
`ifdef INV_SBOX_SELFCHECK_EN
   ,
   output logic         ters_hata
`endif
);

   localparam int BPC = BYTES_PER_CYCLE;
   localparam int GW  = 8 * BPC;

   if (BPC != 1 && BPC != 2 && BPC != 4 && BPC != 8 && BPC != 16) begin : g_bpc_hatali
      $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end

   // Standard inverse Rijndael S-box, entry n is InvS(n).
   localparam logic [7:0] TERS_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   typedef enum logic [1:0] {
      BOSTA = 2'd0,
      ISLE  = 2'd1,
      HAZIR = 2'd2
   } durum_t;

   durum_t         durum;
   durum_t         durum_sonraki;
   logic [4:0]     sayac;
   logic [5:0]     sayac_toplam;
   logic           son_grup;
   logic [127:0]   giris_reg;
   logic [127:0]   cikis_reg;
   logic [GW-1:0]  grup_giris;
   logic [GW-1:0]  grup_cikis;

   // Counter is 5 bits wide; the sum is kept 6 bits so BPC=16 does not alias to zero.
   assign sayac_toplam = {1'b0, sayac} + 6'(BPC);
   assign son_grup     = (sayac_toplam == 6'd16);

   // sayac is always a multiple of BPC, so the group starts on a byte boundary.
   assign grup_giris = giris_reg[{sayac[3:0], 3'b000} +: GW];

   for (genvar k = 0; k < BPC; k++) begin : g_ters_sbox
      assign grup_cikis[8*k +: 8] = TERS_SBOX[grup_giris[8*k +: 8]];
   end

   assign cikan_kod = cikis_reg;

   // State register; reset returns to BOSTA from any state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         durum <= BOSTA;
      end else begin
         durum <= durum_sonraki;
      end
   end

   // Next-state and handshake outputs; HAZIR->BOSTA costs a cycle so accept never shares the consume edge.
   always_comb begin
      durum_sonraki = durum;
      giren_hazir   = 1'b0;
      cikan_gecerli = 1'b0;
      case (durum)
         BOSTA: begin
            giren_hazir = 1'b1;
            if (giren_gecerli) begin
               durum_sonraki = ISLE;
            end
         end
         ISLE: begin
            if (son_grup) begin
               durum_sonraki = HAZIR;
            end
         end
         HAZIR: begin
            cikan_gecerli = 1'b1;
            if (cikan_hazir) begin
               durum_sonraki = BOSTA;
            end
         end
         default: durum_sonraki = BOSTA;
      endcase
   end

   // Datapath: capture input on accept, then substitute one group per ISLE cycle in ascending byte order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         giris_reg <= '0;
         cikis_reg <= '0;
         sayac     <= '0;
      end else begin
         case (durum)
            BOSTA: begin
               if (giren_gecerli) begin
                  giris_reg <= giren_kod;
                  cikis_reg <= '0;
                  sayac     <= '0;
               end
            end
            ISLE: begin
               cikis_reg[{sayac[3:0], 3'b000} +: GW] <= grup_cikis;
               sayac <= sayac_toplam[4:0];
            end
            default: ;
         endcase
      end
   end

`ifdef INV_SBOX_SELFCHECK_EN
   function automatic logic [7:0] gf_carp(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) begin
            p = p ^ aa;
         end
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Forward S-box: multiplicative inverse as x^254, then the affine map.
   function automatic logic [7:0] ileri_sbox(input logic [7:0] x);
      logic [7:0] kare;
      logic [7:0] ters;
      kare = x;
      ters = 8'h01;
      for (int i = 1; i < 8; i++) begin
         kare = gf_carp(kare, kare);
         ters = gf_carp(ters, kare);
      end
      return ters ^ {ters[6:0], ters[7]} ^ {ters[5:0], ters[7:6]}
                  ^ {ters[4:0], ters[7:5]} ^ {ters[3:0], ters[7:4]} ^ 8'h63;
   endfunction

   logic [BPC-1:0] uyumsuz;

   for (genvar k = 0; k < BPC; k++) begin : g_oz_denetim
      assign uyumsuz[k] = (ileri_sbox(grup_cikis[8*k +: 8]) != grup_giris[8*k +: 8]);
   end

   // Sticky error: any substituted byte that does not map back to its source.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ters_hata <= 1'b0;
      end else if (durum == ISLE && (|uyumsuz)) begin
         ters_hata <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_ters_bit_degistirme.sv
// Bench for ters_bit_degistirme: directed jobs plus byte-space sweep.
// Expected results come from an arithmetic forward S-box inverted into a lookup table.
// Scoreboard queue is filled on accept and drained on each output handshake.
module tb_ters_bit_degistirme;

   parameter int BPC = 4;

   logic         clk;
   logic         rst;
   logic         giren_gecerli;
   logic         giren_hazir;
   logic [127:0] giren_kod;
   logic         cikan_gecerli;
   logic         cikan_hazir;
   logic [127:0] cikan_kod;
`ifdef INV_SBOX_SELFCHECK_EN
   logic         ters_hata;
`endif

   int checks   = 0;
   int failures = 0;

   logic [7:0]   inv_tbl [256];
   logic [127:0] exp_q [$];

   ters_bit_degistirme #(.BYTES_PER_CYCLE(BPC)) dut (
      .clk           (clk),
      .rst           (rst),
      .giren_gecerli (giren_gecerli),
      .giren_hazir   (giren_hazir),
      .giren_kod     (giren_kod),
      .cikan_gecerli (cikan_gecerli),
      .cikan_hazir   (cikan_hazir),
      .cikan_kod     (cikan_kod)
`ifdef INV_SBOX_SELFCHECK_EN
      ,
      .ters_hata     (ters_hata)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] fwd(input logic [7:0] x);
      logic [7:0] p;
      p = 8'h01;
      for (int i = 0; i < 254; i++) p = gmul(p, x);
      return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] model(input logic [127:0] k);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tbl[k[8*i +: 8]];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one job; its expected result enters the scoreboard on the accept edge.
   task automatic accept(input logic [127:0] kod, input logic [127:0] beklenen);
      int n;
      n = 0;
      while (giren_hazir !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      giren_kod     = kod;
      giren_gecerli = 1'b1;
      exp_q.push_back(beklenen);
      tick();
      giren_gecerli = 1'b0;
      giren_kod     = ~kod;
   endtask

   task automatic wait_out(input string tag);
      int n;
      n = 0;
      while (cikan_gecerli !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, 128'(n), 128'(16 / BPC));
   endtask

   task automatic consume(input string tag);
      logic [127:0] e;
      e = 'x;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      chk({tag, "_valid"}, 128'(cikan_gecerli), 128'(1));
      chk({tag, "_kod"}, cikan_kod, e);
      cikan_hazir = 1'b1;
      tick();
   endtask

   initial begin
      logic [127:0] t2_in, t2_out, a_in, b_in, k;

      for (int x = 0; x < 256; x++) inv_tbl[fwd(8'(x))] = 8'(x);
      t2_in  = 128'h76abd7fe2b670130c56f6bf27b777c63;
      t2_out = 128'h0f0e0d0c0b0a09080706050403020100;

      rst = 1'b1;
      giren_gecerli = 1'b0;
      giren_kod     = '0;
      cikan_hazir   = 1'b1;
      tick();
      tick();
      chk("reset_giren_hazir", 128'(giren_hazir), 128'(1));
      chk("reset_cikan_gecerli", 128'(cikan_gecerli), 128'(0));
      chk("reset_cikan_kod", cikan_kod, 128'h0);
`ifdef INV_SBOX_SELFCHECK_EN
      chk("reset_ters_hata", 128'(ters_hata), 128'(0));
`endif
      rst = 1'b0;
      tick();

      // T1: all 0x63 -> all zero, valid for exactly one cycle
      accept({16{8'h63}}, 128'h0);
      wait_out("t1");
      consume("t1");
      chk("t1_valid_one_cycle", 128'(cikan_gecerli), 128'(0));
      chk("t1_giren_hazir_after", 128'(giren_hazir), 128'(1));

      // T2: counting vector; result holds in BOSTA
      accept(t2_in, t2_out);
      wait_out("t2");
      consume("t2");
      tick();
      tick();
      chk("t2_hold_in_bosta", cikan_kod, t2_out);

      // T3: uniform patterns and table spots
      accept({16{8'h16}}, {16{8'hff}});
      wait_out("t3a");
      consume("t3a");
      accept(128'h0, {16{8'h52}});
      wait_out("t3b");
      consume("t3b");
      k = '0;
      k[7:0]  = 8'hed;
      k[15:8] = 8'h7c;
      accept(k, model(k));
      wait_out("t3c");
      chk("t3_invs_ed", 128'(cikan_kod[7:0]), 128'(8'h53));
      chk("t3_invs_7c", 128'(cikan_kod[15:8]), 128'(8'h01));
      consume("t3c");

      // T4: backpressure with a stray input pulse; no accept on the consume edge
      a_in = {$urandom, $urandom, $urandom, $urandom};
      b_in = {$urandom, $urandom, $urandom, $urandom};
      cikan_hazir = 1'b0;
      accept(a_in, model(a_in));
      wait_out("t4a");
      for (int c = 0; c < 10; c++) begin
         chk("t4_hold_kod", cikan_kod, model(a_in));
         chk("t4_hold_valid", 128'(cikan_gecerli), 128'(1));
         chk("t4_giren_hazir_low", 128'(giren_hazir), 128'(0));
         if (c == 3) begin
            giren_gecerli = 1'b1;
            giren_kod     = b_in;
         end
         if (c == 4) giren_gecerli = 1'b0;
         tick();
      end
      giren_gecerli = 1'b1;
      giren_kod     = b_in;
      consume("t4a");
      chk("t4_no_accept_on_consume", 128'(giren_hazir), 128'(1));
      chk("t4_valid_drop", 128'(cikan_gecerli), 128'(0));
      accept(b_in, model(b_in));
      wait_out("t4b");
      consume("t4b");

      // T5: reset in the second ISLE cycle, then a clean job
      accept(t2_in, t2_out);
      tick();
      rst = 1'b1;
      #1;
      chk("t5_rst_giren_hazir", 128'(giren_hazir), 128'(1));
      chk("t5_rst_cikan_gecerli", 128'(cikan_gecerli), 128'(0));
      chk("t5_rst_cikan_kod", cikan_kod, 128'h0);
      void'(exp_q.pop_back());
      #2;
      rst = 1'b0;
      tick();
      chk("t5_idle_after_rst", 128'(cikan_gecerli), 128'(0));
      accept(t2_in, t2_out);
      wait_out("t5");
      consume("t5");

      // Random states
      for (int r = 0; r < 4; r++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         accept(k, model(k));
         wait_out("rand");
         consume("rand");
      end

      // T6: every byte value once, 16 jobs
      for (int j = 0; j < 16; j++) begin
         for (int i = 0; i < 16; i++) k[8*i +: 8] = 8'(16 * j + i);
         accept(k, model(k));
         wait_out("sweep");
         consume("sweep");
      end
`ifdef INV_SBOX_SELFCHECK_EN
      chk("t6_ters_hata", 128'(ters_hata), 128'(0));
`endif
      chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
